// File: rtl/spike_train_decoder.sv
`timescale 1ns/1ps
// spike_train_decoder: hysteretic spike detector with inter-spike interval and windowed rate readout.
// Optional burst detector is compiled in when BURST_DETECT_EN is defined.
module spike_train_decoder #(
    parameter logic signed [7:0] THRESH      = 8'sd19,
    parameter logic signed [7:0] REARM       = -8'sd8,
    parameter int                ISI_W       = 12,
    parameter int                WINDOW_LOG2 = 10,
    parameter int                BURST_ISI   = 16,
    parameter int                BURST_N     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic signed [7:0]       v_in,
    output logic                    spike,
    output logic                    armed,
    output logic [ISI_W-1:0]        isi_out,
    output logic                    isi_valid,
    output logic                    isi_sat,
    output logic [7:0]              rate_out,
    output logic                    rate_valid,
    output logic                    burst
);

    if (REARM >= THRESH || BURST_N < 1 || BURST_ISI < 1) begin : g_bad_params
        $error("spike_train_decoder: REARM must be below THRESH; BURST_N and BURST_ISI must be positive");
    end

    typedef enum logic {ST_ARMED, ST_FIRED} state_t;

    localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   fire;
    logic                   spike_q, spike_d;
    logic                   have_prev_q, have_prev_d;
    logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0]       isi_out_q, isi_out_d;
    logic                   isi_valid_q, isi_valid_d;
    logic                   isi_sat_q, isi_sat_d;
    logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]             spk_cnt_q, spk_cnt_d, spk_cnt_nxt;
    logic [7:0]             rate_out_q, rate_out_d;
    logic                   rate_valid_q, rate_valid_d;

    function automatic logic [ISI_W-1:0] isi_inc(input logic [ISI_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    function automatic logic [7:0] cnt8_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        fire         = 1'b0;
        have_prev_d  = have_prev_q;
        isi_cnt_d    = isi_cnt_q;
        isi_out_d    = isi_out_q;
        isi_valid_d  = 1'b0;
        isi_sat_d    = isi_sat_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_nxt  = spk_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = 1'b0;

        if (ena) begin
            case (state_q)
                ST_ARMED: if (v_in > THRESH) begin
                    fire    = 1'b1;
                    state_d = ST_FIRED;
                end
                ST_FIRED: if (v_in < REARM) state_d = ST_ARMED;
                default:  state_d = ST_ARMED;
            endcase

            isi_cnt_d = fire ? ISI_ONE : isi_inc(isi_cnt_q);
            if (fire) begin
                if (have_prev_q) begin
                    isi_out_d   = isi_cnt_q;
                    isi_valid_d = 1'b1;
                    isi_sat_d   = (isi_cnt_q == '1);
                end
                have_prev_d = 1'b1;
                spk_cnt_nxt = cnt8_inc(spk_cnt_q);
            end

            // a spike landing on the wrap cycle is credited to the window that is closing
            win_cnt_d = win_cnt_q + 1'b1;
            if (win_cnt_q == '1) begin
                rate_out_d   = spk_cnt_nxt;
                rate_valid_d = 1'b1;
                spk_cnt_d    = 8'd0;
            end else begin
                spk_cnt_d    = spk_cnt_nxt;
            end
        end
        spike_d = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARMED;
            spike_q      <= 1'b0;
            have_prev_q  <= 1'b0;
            isi_cnt_q    <= '0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
            isi_sat_q    <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= 8'd0;
            rate_out_q   <= 8'd0;
            rate_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_d;
            have_prev_q  <= have_prev_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
            isi_sat_q    <= isi_sat_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign spike      = spike_q;
    assign armed      = (state_q == ST_ARMED);
    assign isi_out    = isi_out_q;
    assign isi_valid  = isi_valid_q;
    assign isi_sat    = isi_sat_q;
    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;

`ifdef BURST_DETECT_EN
    localparam int               RUN_W       = $clog2(BURST_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(BURST_N);
    localparam logic [ISI_W-1:0] BURST_ISI_V = ISI_W'(BURST_ISI);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             burst_q, burst_d;

    // a long interval or a silent gap of BURST_ISI cycles both end the burst
    always_comb begin
        run_cnt_d = run_cnt_q;
        burst_d   = burst_q;
        if (ena) begin
            if (fire && have_prev_q) begin
                if (isi_cnt_q < BURST_ISI_V) begin
                    run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
                    burst_d   = burst_q | (run_cnt_d == RUN_MAX);
                end else begin
                    run_cnt_d = '0;
                    burst_d   = 1'b0;
                end
            end else if (!fire && isi_cnt_d == BURST_ISI_V) begin
                run_cnt_d = '0;
                burst_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            burst_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            burst_q   <= burst_d;
        end
    end

    assign burst = burst_q;
`else
    assign burst = 1'b0;
`endif

endmodule
